pairhmm_data_pkt_top: RTL and testbench

Packet ingest and streaming front end of the PairHMM accelerator. The CPU writes one packet of 128-bit words into an internal buffer. It then pulses `cpu_pkt_done`, and the block replays the packet payload to the matrix engine, paced by `matrix_enable`. While streaming, the block accumulates a 32-bit lane checksum over the payload and reports it on completion.

---
 rtl/pairhmm_data_pkt_pkg.sv | 21 ++
 rtl/pairhmm_data_pkt_read_analyze.sv | 100 ++++++++++
 rtl/pairhmm_data_pkt_top.sv | 85 ++++++++
 tb/tb_pairhmm_data_pkt_top.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pairhmm_data_pkt_pkg.sv
// data_pkt_pkg: shared constants and types for the PairHMM packet front end.
//   PKT_ADDR_W / PKT_DATA_W : default buffer address and word widths
//   CNT_MSB / CNT_LSB       : header field that holds the payload word count
//   SUM_W                   : checksum / lane width
//   pkt_state_e             : streaming FSM states
package data_pkt_pkg;

    localparam int unsigned PKT_ADDR_W = 14;
    localparam int unsigned PKT_DATA_W = 128;
    localparam int unsigned SUM_W      = 32;
    localparam int unsigned CNT_LSB    = 0;
    localparam int unsigned CNT_MSB    = PKT_ADDR_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_FINISH
    } pkt_state_e;

endpackage

// File: rtl/pairhmm_data_pkt_read_analyze.sv
// pkt_read_analyze: packet replay FSM, read-address counter, valid/last
// register and running lane checksum.
//   clk, rst_n     : clock, synchronous active-low reset
//   done           : packet-complete pulse (only honoured in IDLE)
//   hdr_count      : payload word count from the header shadow
//   matrix_enable  : engine ready; gates issuing of reads
//   rd_data        : registered RAM read data (also the streamed word)
//   rd_en, rd_addr : RAM read request
//   busy           : packet in progress
//   mtx_vld/last   : rd_data valid / final payload word
//   finish         : one-cycle end-of-packet pulse
//   pkt_sum        : running checksum
module pkt_read_analyze
    import data_pkt_pkg::*;
#(
    parameter int unsigned ADDR_W = PKT_ADDR_W,
    parameter int unsigned DATA_W = PKT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done,
    input  logic [ADDR_W-1:0] hdr_count,
    input  logic              matrix_enable,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              mtx_vld,
    output logic              mtx_last,
    output logic              finish,
    output logic [SUM_W-1:0]  pkt_sum
);

    localparam int unsigned LANES = DATA_W / SUM_W;

    pkt_state_e        state;
    pkt_state_e        state_nxt;
    logic [ADDR_W-1:0] count;
    logic [SUM_W-1:0]  word_sum;
    logic              start;
    logic              issue_last;

    assign start      = (state == ST_IDLE) && done;
    assign issue_last = rd_en && (rd_addr == count);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (done) state_nxt = (hdr_count == '0) ? ST_FINISH : ST_STREAM;
            ST_STREAM: if (issue_last) state_nxt = ST_DRAIN;
            // the last word is in the read register during this cycle
            ST_DRAIN:  if (mtx_vld && mtx_last) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        busy   = (state != ST_IDLE);
        rd_en  = (state == ST_STREAM) && matrix_enable;
        finish = (state == ST_FINISH);
    end

    always_comb begin
        word_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            word_sum = word_sum + rd_data[i*SUM_W +: SUM_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            rd_addr  <= '0;
            mtx_vld  <= 1'b0;
            mtx_last <= 1'b0;
            pkt_sum  <= '0;
        end else begin
            mtx_vld  <= rd_en;
            mtx_last <= issue_last;
            if (start) begin
                count   <= hdr_count;
                rd_addr <= ADDR_W'(1);
                pkt_sum <= '0;
            end else begin
                if (rd_en)   rd_addr <= rd_addr + ADDR_W'(1);
                if (mtx_vld) pkt_sum <= pkt_sum + word_sum;
            end
        end
    end

endmodule

// File: rtl/pairhmm_data_pkt_top.sv
// pairhmm_data_pkt_top: CPU packet ingest buffer and replay front end.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   cpu_pkt_*          : CPU word writes and packet-complete pulse
//   matrix_enable      : engine ready level
//   pkt_busy           : packet being streamed
//   mtx_data/vld/last  : streamed payload
//   pkt_finish         : end-of-packet pulse
//   pkt_sum            : payload lane checksum
//   pkt_err            : pulse on write or done dropped while busy
module pairhmm_data_pkt_top
    import data_pkt_pkg::*;
#(
    parameter int unsigned ADDR_W = PKT_ADDR_W,
    parameter int unsigned DATA_W = PKT_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] cpu_pkt_data,
    input  logic [ADDR_W-1:0] cpu_pkt_waddr,
    input  logic              cpu_pkt_vld,
    input  logic              cpu_pkt_done,
    input  logic              matrix_enable,
    output logic              pkt_busy,
    output logic [DATA_W-1:0] mtx_data,
    output logic              mtx_vld,
    output logic              mtx_last,
    output logic              pkt_finish,
    output logic [SUM_W-1:0]  pkt_sum,
    output logic              pkt_err
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] hdr_count;
    logic              wr_ok;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    assign wr_ok = cpu_pkt_vld && !pkt_busy;

    // buffer storage is never reset
    always_ff @(posedge sys_clk) begin
        if (wr_ok) mem[cpu_pkt_waddr] <= cpu_pkt_data;
    end

    // read register doubles as the stream output; it only loads on a read so
    // mtx_data holds between words
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)  mtx_data <= '0;
        else if (rd_en)  mtx_data <= mem[rd_addr];
    end

    // a done in the same cycle as a header write sees the old count
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            hdr_count <= '0;
        end else if (wr_ok && (cpu_pkt_waddr == '0)) begin
            hdr_count <= cpu_pkt_data[CNT_MSB:CNT_LSB];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) pkt_err <= 1'b0;
        else            pkt_err <= pkt_busy && (cpu_pkt_vld || cpu_pkt_done);
    end

    pkt_read_analyze #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_read_analyze (
        .clk           (sys_clk),
        .rst_n         (sys_rst_n),
        .done          (cpu_pkt_done),
        .hdr_count     (hdr_count),
        .matrix_enable (matrix_enable),
        .rd_data       (mtx_data),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .busy          (pkt_busy),
        .mtx_vld       (mtx_vld),
        .mtx_last      (mtx_last),
        .finish        (pkt_finish),
        .pkt_sum       (pkt_sum)
    );

endmodule

// File: tb/tb_pairhmm_data_pkt_top.sv
// Self-checking bench for pairhmm_data_pkt_top: a behavioural packet model
// predicts every output each cycle; directed scenarios add literal checks.
`timescale 1ns/1ps
module tb_pairhmm_data_pkt_top;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [127:0] cpu_pkt_data = '0;
    logic [13:0]  cpu_pkt_waddr = '0;
    logic         cpu_pkt_vld = 1'b0;
    logic         cpu_pkt_done = 1'b0;
    logic         matrix_enable = 1'b0;
    logic         pkt_busy;
    logic [127:0] mtx_data;
    logic         mtx_vld;
    logic         mtx_last;
    logic         pkt_finish;
    logic [31:0]  pkt_sum;
    logic         pkt_err;

    always #5 sys_clk = ~sys_clk;

    pairhmm_data_pkt_top #(
        .ADDR_W (14),
        .DATA_W (128)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .cpu_pkt_data  (cpu_pkt_data),
        .cpu_pkt_waddr (cpu_pkt_waddr),
        .cpu_pkt_vld   (cpu_pkt_vld),
        .cpu_pkt_done  (cpu_pkt_done),
        .matrix_enable (matrix_enable),
        .pkt_busy      (pkt_busy),
        .mtx_data      (mtx_data),
        .mtx_vld       (mtx_vld),
        .mtx_last      (mtx_last),
        .pkt_finish    (pkt_finish),
        .pkt_sum       (pkt_sum),
        .pkt_err       (pkt_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [127:0] d);
        return d[31:0] + d[63:32] + d[95:64] + d[127:96];
    endfunction

    // ---------------- behavioural model ----------------
    logic [127:0] m_mem [16384];
    logic [13:0]  m_hdr = '0;
    int           m_next = 0;
    int           m_count = 0;
    bit           m_stream = 0;
    bit           chk_on = 0;
    bit           e_busy = 0, e_vld = 0, e_last = 0, e_fin = 0, e_err = 0;
    logic [127:0] e_data = '0;
    logic [31:0]  e_sum = '0;

    always @(posedge sys_clk) begin : model
        bit cv, cl, cf, cb;
        if (!sys_rst_n) begin
            e_busy = 0; e_vld = 0; e_last = 0; e_fin = 0; e_err = 0;
            e_data = '0; e_sum = '0; m_hdr = '0; m_stream = 0;
            chk_on = 1;
        end else begin
            cv = e_vld; cl = e_last; cf = e_fin; cb = e_busy;
            e_err = cb && (cpu_pkt_vld || cpu_pkt_done);
            if (cv) e_sum = e_sum + lanes(e_data);
            e_vld  = 0;
            e_last = 0;
            e_fin  = cv && cl;
            if (m_stream && matrix_enable) begin
                e_vld  = 1;
                e_data = m_mem[m_next];
                e_last = (m_next == m_count);
                if (e_last) m_stream = 0;
                m_next++;
            end
            if (cf) begin
                e_busy = 0;
            end else if (!cb && cpu_pkt_done) begin
                e_busy = 1;
                e_sum  = '0;
                if (m_hdr == 0) begin
                    e_fin = 1;
                end else begin
                    m_stream = 1;
                    m_next   = 1;
                    m_count  = int'(m_hdr);
                end
            end
            if (cpu_pkt_vld && !cb) begin
                m_mem[cpu_pkt_waddr] = cpu_pkt_data;
                if (cpu_pkt_waddr == 0) m_hdr = cpu_pkt_data[13:0];
            end
        end
    end

    // ---------------- compare process ----------------
    int n_vld = 0, n_last = 0, n_fin = 0, n_err = 0;

    always @(negedge sys_clk) begin
        if (chk_on) begin
            check("pkt_busy",   pkt_busy,   e_busy);
            check("mtx_vld",    mtx_vld,    e_vld);
            check("mtx_last",   mtx_last,   e_last);
            check("mtx_data",   mtx_data,   e_data);
            check("pkt_finish", pkt_finish, e_fin);
            check("pkt_sum",    pkt_sum,    e_sum);
            check("pkt_err",    pkt_err,    e_err);
            if (mtx_vld) n_vld++;
            if (mtx_vld && mtx_last) n_last++;
            if (pkt_finish) n_fin++;
            if (pkt_err) n_err++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wr(input logic [13:0] a, input logic [127:0] d);
        cpu_pkt_vld = 1'b1; cpu_pkt_waddr = a; cpu_pkt_data = d;
        @(negedge sys_clk);
        cpu_pkt_vld = 1'b0;
    endtask

    task automatic done_pulse();
        cpu_pkt_done = 1'b1;
        @(negedge sys_clk);
        cpu_pkt_done = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while ((pkt_busy || e_busy) && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", nm, k);
        end
        cyc(1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stim
        int b_vld, b_last, b_fin, b_err;
        int len;

        cyc(2);
        sys_rst_n = 1'b1;
        check("rst_busy", pkt_busy, 0);
        check("rst_sum",  pkt_sum,  0);
        check("rst_data", mtx_data, 0);

        // empty packet: header shadow is 0 after reset
        b_vld = n_vld;
        done_pulse();
        check("empty_finish", pkt_finish, 1);
        check("empty_busy",   pkt_busy,   1);
        check("empty_sum",    pkt_sum,    0);
        cyc(1);
        check("empty_busy_after", pkt_busy, 0);
        check("empty_no_vld", n_vld - b_vld, 0);

        // 3-word stream
        wr(14'd0, 128'd3);
        wr(14'd1, {32'd1, 32'd2, 32'd3, 32'd4});
        wr(14'd2, '1);
        wr(14'd3, 128'd197121);
        matrix_enable = 1'b1;
        b_vld = n_vld; b_last = n_last; b_fin = n_fin;
        done_pulse();
        wait_idle("three_idle", 50);
        check("three_nvld",  n_vld - b_vld, 3);
        check("three_nlast", n_last - b_last, 1);
        check("three_nfin",  n_fin - b_fin, 1);
        check("three_sum",   pkt_sum, 32'h0003_0207);
        check("three_model_sum", e_sum, 32'h0003_0207);

        // pacing with busy-time writes and done dropped
        b_vld = n_vld; b_err = n_err;
        done_pulse();
        cyc(1);
        matrix_enable = 1'b0;
        wr(14'd2, rnd128());
        wr(14'd0, 128'd7);
        done_pulse();
        cyc(2);
        matrix_enable = 1'b1;
        wait_idle("pace_idle", 50);
        check("pace_nvld", n_vld - b_vld, 3);
        check("pace_nerr", n_err - b_err, 3);
        check("pace_sum",  pkt_sum, 32'h0003_0207);

        // buffer and header untouched by dropped writes
        b_vld = n_vld;
        done_pulse();
        wait_idle("again_idle", 50);
        check("again_nvld", n_vld - b_vld, 3);
        check("again_sum",  pkt_sum, 32'h0003_0207);

        // reset mid-stream
        b_fin = n_fin;
        done_pulse();
        cyc(1);
        sys_rst_n = 1'b0;
        cyc(1);
        sys_rst_n = 1'b1;
        check("mid_rst_busy", pkt_busy, 0);
        check("mid_rst_vld",  mtx_vld,  0);
        check("mid_rst_sum",  pkt_sum,  0);
        cyc(3);
        check("mid_rst_nfin", n_fin - b_fin, 0);
        wr(14'd0, 128'd2);
        b_vld = n_vld;
        done_pulse();
        wait_idle("two_idle", 50);
        check("two_nvld", n_vld - b_vld, 2);
        check("two_sum",  pkt_sum, 32'h0000_0006);

        // header write and done in the same cycle: done sees the old count (2)
        cpu_pkt_vld = 1'b1; cpu_pkt_waddr = 14'd0; cpu_pkt_data = 128'd5;
        cpu_pkt_done = 1'b1;
        b_vld = n_vld;
        @(negedge sys_clk);
        cpu_pkt_vld = 1'b0; cpu_pkt_done = 1'b0;
        wait_idle("simul_idle", 50);
        check("simul_nvld", n_vld - b_vld, 2);
        wr(14'd4, rnd128());
        wr(14'd5, rnd128());
        b_vld = n_vld;
        done_pulse();
        wait_idle("five_idle", 50);
        check("five_nvld", n_vld - b_vld, 5);

        // randomized packets with random pacing and busy-time pokes
        for (int p = 0; p < 25; p++) begin
            len = int'($urandom_range(1, 12));
            for (int a = 1; a <= len; a++) wr(14'(a), rnd128());
            wr(14'd0, {rnd128() >> 14, 14'(len)} );
            matrix_enable = ($urandom_range(0, 3) != 0);
            b_vld = n_vld;
            done_pulse();
            for (int k = 0; k < 200 && (pkt_busy || e_busy); k++) begin
                matrix_enable = ($urandom_range(0, 2) != 0);
                cpu_pkt_vld   = ($urandom_range(0, 7) == 0);
                cpu_pkt_done  = ($urandom_range(0, 9) == 0) && e_busy;
                cpu_pkt_waddr = 14'($urandom_range(0, 15));
                cpu_pkt_data  = rnd128();
                @(negedge sys_clk);
            end
            cpu_pkt_vld = 1'b0; cpu_pkt_done = 1'b0;
            matrix_enable = 1'b1;
            wait_idle("rand_idle", 100);
        end

        // maximum count
        for (int a = 1; a < 16384; a++) wr(14'(a), rnd128());
        wr(14'd0, {114'd0, 14'd16383});
        matrix_enable = 1'b1;
        b_vld = n_vld; b_last = n_last; b_fin = n_fin;
        done_pulse();
        wait_idle("max_idle", 17000);
        check("max_nvld",  n_vld - b_vld, 16383);
        check("max_nlast", n_last - b_last, 1);
        check("max_nfin",  n_fin - b_fin, 1);

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
